// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative SLL/SRL/SRA shifter for the multicycle core.
// Moves at most STEP bits per clock. Valid/ready on both sides so that EX
// can stall on it.
// Optional build macro SEQ_SHIFT_ROTATE_EN adds a 'rot' input. When rot is
// high the unit rotates instead of shifting.
module seq_shift_unit #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             funct3_2,
  input  logic             funct7,
`ifdef SEQ_SHIFT_ROTATE_EN
  input  logic             rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // STEP may equal WIDTH, which does not fit in SHW bits, so compare one bit wider
  localparam logic [SHW:0] STEP_C = (SHW+1)'(STEP);

  state_t         state, state_next;
  logic [SHW-1:0] rem;
  logic [SHW-1:0] k;
  logic [SHW-1:0] rem_next;
  logic           dir;
  logic           fill;
  logic           rot_q;
  logic           rot_in;

  // Bits moved this cycle: k = min(STEP, rem), so rem never underflows
  function automatic logic [SHW-1:0] step_amt(input logic [SHW-1:0] r);
    if ({1'b0, r} < STEP_C) return r;
    return STEP_C[SHW-1:0];
  endfunction

  // One partial shift or rotate by kk in direction d (1 = right), inserting f on right shifts
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v,
                                                  input logic [SHW-1:0]   kk,
                                                  input logic             d,
                                                  input logic             f,
                                                  input logic             r);
    logic signed [WIDTH:0] ext;
    logic [SHW:0]          back;
    back = (SHW+1)'(WIDTH) - {1'b0, kk};
    if (r) return d ? ((v >> kk) | (v << back)) : ((v << kk) | (v >> back));
    if (!d) return v << kk;
    ext = {f, v};
    ext = ext >>> kk;
    return ext[WIDTH-1:0];
  endfunction

`ifdef SEQ_SHIFT_ROTATE_EN
  assign rot_in = rot;
`else
  assign rot_in = 1'b0;
`endif

  assign k        = step_amt(rem);
  assign rem_next = rem - k;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> SHIFT|DONE, SHIFT -> DONE, DONE -> IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid) state_next = (shamt == '0) ? DONE : SHIFT;
      SHIFT:   if (rem_next == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture at accept, then one partial shift per SHIFT cycle; frozen otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      rem    <= '0;
      dir    <= 1'b0;
      fill   <= 1'b0;
      rot_q  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      result <= a;
      rem    <= shamt;
      dir    <= funct3_2;
      fill   <= (funct3_2 && funct7) ? a[WIDTH-1] : 1'b0;
      rot_q  <= rot_in;
    end else if (state == SHIFT) begin
      result <= shift_once(result, k, dir, fill, rot_q);
      rem    <= rem_next;
    end
  end

endmodule
